// File: rtl/pipeline_run_ctrl_pkg.sv
// Shared definitions for the debugger pipeline run controller:
// command codes, state encoding and the state-to-output decode.
package pipeline_run_ctrl_pkg;

   localparam logic [1:0] CMD_NOP  = 2'b00;
   localparam logic [1:0] CMD_RUN  = 2'b01;
   localparam logic [1:0] CMD_STEP = 2'b10;
   localparam logic [1:0] CMD_STOP = 2'b11;

   localparam logic [5:0]  HALT_OPCODE_DEF  = 6'b111111;
   localparam int unsigned DRAIN_CYCLES_DEF = 4;
   localparam int unsigned CYC_W_DEF        = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_STEP  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DUMP  = 3'd4
   } state_e;

   typedef struct packed {
      logic ena_pip;
      logic cmd_ready;
      logic busy;
      logic dump_req;
   } ctrl_out_t;

   // Output levels that belong to a given state
   function automatic ctrl_out_t decode_state(input state_e s);
      ctrl_out_t o;
      o.ena_pip   = (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
      o.cmd_ready = (s == ST_IDLE) || (s == ST_RUN) || (s == ST_DRAIN);
      o.busy      = (s != ST_IDLE);
      o.dump_req  = (s == ST_DUMP);
      return o;
   endfunction

endpackage

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipeline_run_ctrl_sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_value
);

   logic [W-1:0] r_value;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_value <= '0;
      end else if (i_clr) begin
         r_value <= '0;
      end else if (i_inc && (r_value != '1)) begin
         r_value <= r_value + W'(1);
      end
   end

   assign o_value = r_value;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Debugger run/step/stop sequencer: drives the pipeline enable, drains the
// pipe after a halt opcode at IF and hands off to the UART dump.
module pipeline_run_ctrl
   import pipeline_run_ctrl_pkg::*;
#(
   parameter logic [5:0]  HALT_OPCODE  = HALT_OPCODE_DEF,
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int unsigned CYC_W        = CYC_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_code,
   output logic             cmd_ready,
   input  logic [31:0]      instruction_IF,
   output logic             ena_pip,
   output logic             dump_req,
   input  logic             dump_ack,
   output logic             busy,
   output logic             halted,
   output logic [CYC_W-1:0] cycle_count
);

   localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES - 1);

   if (DRAIN_CYCLES == 0) begin : g_bad_drain
      $error("pipeline_run_ctrl: DRAIN_CYCLES must be at least 1");
   end

   state_e           r_state;
   ctrl_out_t        r_out;
   logic             r_halted;
   logic [DRN_W-1:0] r_drain;

   state_e           w_state_nxt;
   logic             w_halted_nxt;
   logic [DRN_W-1:0] w_drain_nxt;
   logic             w_accept;
   logic             w_stop;
   logic             w_halt_seen;
   logic             w_clr;
   logic [CYC_W-1:0] w_count;
   logic             w_unused_instr;

   assign w_accept       = cmd_valid & r_out.cmd_ready;
   assign w_stop         = w_accept && (cmd_code == CMD_STOP);
   assign w_halt_seen    = (instruction_IF[31:26] == HALT_OPCODE);
   assign w_unused_instr = ^instruction_IF[25:0];

   // Next-state logic; halt detection only matters while in RUN
   always_comb begin
      w_state_nxt  = r_state;
      w_halted_nxt = r_halted;
      w_drain_nxt  = r_drain;
      w_clr        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (cmd_code)
                  CMD_NOP:  ;
                  CMD_RUN:  if (!r_halted) w_state_nxt = ST_RUN;
                  CMD_STEP: if (!r_halted) w_state_nxt = ST_STEP;
                  CMD_STOP: begin
                     w_halted_nxt = 1'b0;
                     w_clr        = 1'b1;
                  end
               endcase
            end
         end
         ST_RUN: begin
            if (w_stop) begin
               w_state_nxt = ST_DUMP;
            end else if (w_halt_seen) begin
               w_halted_nxt = 1'b1;
               w_drain_nxt  = DRN_LOAD;
               w_state_nxt  = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_stop || (r_drain == '0)) begin
               w_state_nxt = ST_DUMP;
            end else begin
               w_drain_nxt = r_drain - DRN_W'(1);
            end
         end
         ST_STEP: w_state_nxt = ST_DUMP;
         ST_DUMP: if (dump_ack) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State and outputs registered together so outputs track the new state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_out    <= decode_state(ST_IDLE);
         r_halted <= 1'b0;
         r_drain  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_out    <= decode_state(w_state_nxt);
         r_halted <= w_halted_nxt;
         r_drain  <= w_drain_nxt;
      end
   end

   pipeline_run_ctrl_sat_counter #(
      .W (CYC_W)
   ) u_cycle_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (r_out.ena_pip),
      .i_clr   (w_clr),
      .o_value (w_count)
   );

   assign ena_pip     = r_out.ena_pip;
   assign cmd_ready   = r_out.cmd_ready;
   assign busy        = r_out.busy;
   assign dump_req    = r_out.dump_req;
   assign halted      = r_halted;
   assign cycle_count = w_count;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: directed scenarios plus a randomized run
// checked against a behavioural model; a 4-bit counter copy shows saturation.
module tb_pipeline_run_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_code = 2'b00;
   logic [31:0] instruction_IF = 32'h0;
   logic        dump_ack = 1'b0;

   logic        cmd_ready, ena_pip, dump_req, busy, halted;
   logic [31:0] cycle_count;
   logic        cmd_ready_s, ena_pip_s, dump_req_s, busy_s, halted_s;
   logic [3:0]  cycle_count_s;

   int total = 0;
   int bad   = 0;

   pipeline_run_ctrl #(.HALT_OPCODE(6'h3F), .DRAIN_CYCLES(4), .CYC_W(32)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
      .cmd_ready(cmd_ready), .instruction_IF(instruction_IF), .ena_pip(ena_pip),
      .dump_req(dump_req), .dump_ack(dump_ack), .busy(busy), .halted(halted),
      .cycle_count(cycle_count)
   );

   pipeline_run_ctrl #(.HALT_OPCODE(6'h3F), .DRAIN_CYCLES(4), .CYC_W(4)) dut_s (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
      .cmd_ready(cmd_ready_s), .instruction_IF(instruction_IF), .ena_pip(ena_pip_s),
      .dump_req(dump_req_s), .dump_ack(dump_ack), .busy(busy_s), .halted(halted_s),
      .cycle_count(cycle_count_s)
   );

   always #5 clk = ~clk;

   // Behavioural model: what the debugger sees, tracked as a mode name,
   // enabled cycles still owed to the drain, the halt flag and a cycle tally
   localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_DUMP = 4;
   int     m_mode;
   int     m_left;
   bit     m_halted;
   longint m_n;

   task automatic model_reset();
      m_mode = M_IDLE; m_left = 0; m_halted = 1'b0; m_n = 0;
   endtask

   function automatic logic [4:0] model_flags();
      logic en, rdy;
      en  = (m_mode == M_RUN) || (m_mode == M_STEP) || (m_mode == M_DRAIN);
      rdy = (m_mode == M_IDLE) || (m_mode == M_RUN) || (m_mode == M_DRAIN);
      return {en, rdy, m_mode != M_IDLE, m_mode == M_DUMP, m_halted};
   endfunction

   // Predict the effect of the coming rising edge from the current inputs
   task automatic model_edge();
      bit acc, stop;
      acc  = cmd_valid && ((m_mode == M_IDLE) || (m_mode == M_RUN) || (m_mode == M_DRAIN));
      stop = acc && (cmd_code == 2'b11);
      if ((m_mode == M_RUN) || (m_mode == M_STEP) || (m_mode == M_DRAIN)) m_n = m_n + 1;
      case (m_mode)
         M_IDLE: begin
            if (acc && cmd_code == 2'b01 && !m_halted) m_mode = M_RUN;
            else if (acc && cmd_code == 2'b10 && !m_halted) m_mode = M_STEP;
            else if (stop) begin m_halted = 1'b0; m_n = 0; end
         end
         M_RUN: begin
            if (stop) m_mode = M_DUMP;
            else if (instruction_IF[31:26] == 6'h3F) begin
               m_halted = 1'b1; m_left = 4; m_mode = M_DRAIN;
            end
         end
         M_DRAIN: begin
            if (stop) m_mode = M_DUMP;
            else begin
               m_left = m_left - 1;
               if (m_left == 0) m_mode = M_DUMP;
            end
         end
         M_STEP: m_mode = M_DUMP;
         default: if (dump_ack) m_mode = M_IDLE;
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] code);
      cmd_valid = 1'b1;
      cmd_code  = code;
      tick();
      cmd_valid = 1'b0;
      cmd_code  = 2'b00;
   endtask

   function automatic logic [31:0] rand_instr_nohalt();
      logic [5:0] op;
      op = 6'($urandom_range(0, 62));
      return {op, 26'($urandom)};
   endfunction

   task automatic test_reset();
      reset = 1'b0; cmd_valid = 1'b0; dump_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({ena_pip, dump_req, busy, halted, cmd_ready} !== 5'b00001) begin
         bad++;
         $display("FAIL reset_flags: ena/dump/busy/halted/ready got %b want 00001",
                  {ena_pip, dump_req, busy, halted, cmd_ready});
      end
      total++;
      if (cycle_count !== 32'd0) begin
         bad++; $display("FAIL reset_count: got %0d want 0", cycle_count);
      end
      total++;
      if (cycle_count_s !== 4'd0) begin
         bad++; $display("FAIL reset_count_s: got %0d want 0", cycle_count_s);
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_step();
      send(2'b10);
      total++;
      if ({ena_pip, dump_req, busy, cmd_ready} !== 4'b1010) begin
         bad++; $display("FAIL step_enable: ena/dump/busy/ready got %b want 1010",
                         {ena_pip, dump_req, busy, cmd_ready});
      end
      tick();
      total++;
      if ({ena_pip, dump_req, busy, cmd_ready} !== 4'b0110) begin
         bad++; $display("FAIL step_dump: ena/dump/busy/ready got %b want 0110",
                         {ena_pip, dump_req, busy, cmd_ready});
      end
      tick();
      dump_ack = 1'b1;
      tick();
      dump_ack = 1'b0;
      total++;
      if ({ena_pip, dump_req, busy} !== 3'b000 || cycle_count !== 32'd1) begin
         bad++; $display("FAIL step_ack: ena/dump/busy got %b count %0d want 000 count 1",
                         {ena_pip, dump_req, busy}, cycle_count);
      end
   endtask

   task automatic test_run_halt();
      send(2'b11);
      total++;
      if (cycle_count !== 32'd0 || halted !== 1'b0) begin
         bad++; $display("FAIL clear_before_run: count %0d halted %b want 0 0", cycle_count, halted);
      end
      send(2'b01);
      for (int i = 1; i <= 9; i++) begin
         instruction_IF = rand_instr_nohalt();
         total++;
         if (ena_pip !== 1'b1) begin
            bad++; $display("FAIL run_ena: cycle %0d got %b want 1", i, ena_pip);
         end
         tick();
      end
      instruction_IF = 32'hFC00_0000;
      tick();
      total++;
      if ({ena_pip, halted} !== 2'b11 || cycle_count !== 32'd10) begin
         bad++; $display("FAIL halt_seen: ena/halted got %b count %0d want 11 count 10",
                         {ena_pip, halted}, cycle_count);
      end
      for (int i = 0; i < 4; i++) begin
         instruction_IF = ($urandom_range(0, 1) == 0) ? 32'hFC00_0000 : rand_instr_nohalt();
         total++;
         if (ena_pip !== 1'b1) begin
            bad++; $display("FAIL drain_ena: drain cycle %0d got %b want 1", i, ena_pip);
         end
         tick();
      end
      instruction_IF = 32'h0;
      total++;
      if ({ena_pip, dump_req, halted} !== 3'b011 || cycle_count !== 32'd14
          || cycle_count_s !== 4'd14) begin
         bad++; $display("FAIL halt_dump: ena/dump/halted got %b count %0d/%0d want 011 count 14/14",
                         {ena_pip, dump_req, halted}, cycle_count, cycle_count_s);
      end
   endtask

   task automatic test_halted_lockout();
      dump_ack = 1'b1;
      tick();
      dump_ack = 1'b0;
      total++;
      if ({busy, dump_req, halted} !== 3'b001) begin
         bad++; $display("FAIL lock_idle: busy/dump/halted got %b want 001", {busy, dump_req, halted});
      end
      send(2'b01);
      total++;
      if ({ena_pip, busy, halted} !== 3'b001 || cycle_count !== 32'd14) begin
         bad++; $display("FAIL lock_run: ena/busy/halted got %b count %0d want 001 count 14",
                         {ena_pip, busy, halted}, cycle_count);
      end
      send(2'b10);
      total++;
      if ({ena_pip, busy} !== 2'b00) begin
         bad++; $display("FAIL lock_step: ena/busy got %b want 00", {ena_pip, busy});
      end
      send(2'b11);
      total++;
      if (halted !== 1'b0 || cycle_count !== 32'd0) begin
         bad++; $display("FAIL lock_clear: halted %b count %0d want 0 0", halted, cycle_count);
      end
      send(2'b01);
      total++;
      if ({ena_pip, busy} !== 2'b11) begin
         bad++; $display("FAIL unlock_run: ena/busy got %b want 11", {ena_pip, busy});
      end
   endtask

   task automatic test_stop_priority();
      instruction_IF = 32'hFC00_0000;
      send(2'b11);
      instruction_IF = 32'h0;
      total++;
      if ({ena_pip, dump_req, halted, busy} !== 4'b0101) begin
         bad++; $display("FAIL stop_priority: ena/dump/halted/busy got %b want 0101",
                         {ena_pip, dump_req, halted, busy});
      end
      dump_ack = 1'b1;
      tick();
      dump_ack = 1'b0;
      total++;
      if ({busy, dump_req} !== 2'b00) begin
         bad++; $display("FAIL stop_ack: busy/dump got %b want 00", {busy, dump_req});
      end
   endtask

   task automatic test_saturation_reset();
      send(2'b11);
      send(2'b01);
      repeat (19) begin
         instruction_IF = rand_instr_nohalt();
         tick();
      end
      send(2'b11);
      instruction_IF = 32'h0;
      total++;
      if (cycle_count_s !== 4'd15 || cycle_count !== 32'd20) begin
         bad++; $display("FAIL saturate: count_s %0d count %0d want 15 20", cycle_count_s, cycle_count);
      end
      total++;
      if (dump_req !== 1'b1) begin
         bad++; $display("FAIL sat_dump: dump_req got %b want 1", dump_req);
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if ({ena_pip, dump_req, busy, halted, cmd_ready} !== 5'b00001 || cycle_count_s !== 4'd0) begin
         bad++; $display("FAIL async_reset: flags %b count_s %0d want 00001 0",
                         {ena_pip, dump_req, busy, halted, cmd_ready}, cycle_count_s);
      end
      #2 reset = 1'b1;
      tick();
      total++;
      if ({dump_req, busy} !== 2'b00) begin
         bad++; $display("FAIL dump_dropped: dump/busy got %b want 00", {dump_req, busy});
      end
   endtask

   task automatic test_random();
      logic [4:0] exp_f;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      model_reset();
      for (int c = 0; c < 600; c++) begin
         cmd_valid      = ($urandom_range(0, 2) == 0);
         cmd_code       = 2'($urandom_range(0, 3));
         instruction_IF = ($urandom_range(0, 5) == 0) ? {6'h3F, 26'($urandom)} : rand_instr_nohalt();
         dump_ack       = ($urandom_range(0, 3) == 0);
         model_edge();
         tick();
         exp_f = model_flags();
         total++;
         if ({ena_pip, cmd_ready, busy, dump_req, halted} !== exp_f) begin
            bad++; $display("FAIL rand_flags: cycle %0d ena/rdy/busy/dump/halted got %b want %b",
                            c, {ena_pip, cmd_ready, busy, dump_req, halted}, exp_f);
         end
         total++;
         if ({ena_pip_s, cmd_ready_s, busy_s, dump_req_s, halted_s} !== exp_f) begin
            bad++; $display("FAIL rand_flags_s: cycle %0d got %b want %b",
                            c, {ena_pip_s, cmd_ready_s, busy_s, dump_req_s, halted_s}, exp_f);
         end
         total++;
         if (cycle_count !== 32'(m_n) || cycle_count_s !== 4'((m_n > 15) ? 15 : m_n)) begin
            bad++; $display("FAIL rand_count: cycle %0d got %0d/%0d want %0d/%0d", c,
                            cycle_count, cycle_count_s, m_n, (m_n > 15) ? 15 : m_n);
         end
      end
      cmd_valid = 1'b0; dump_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_step();
      test_run_halt();
      test_halted_lockout();
      test_stop_priority();
      test_saturation_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
